// File: rtl/pipe_stage_reg.sv
// Elastic pipeline register with valid/ready handshake and synchronous flush.
// Define PIPE_STAGE_REG_SKID_EN to add a 2nd (skid) entry and register in_ready.
module pipe_stage_reg #(
  parameter int unsigned       WIDTH     = 32,
  parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic             main_vld_q, main_vld_d;
  logic [WIDTH-1:0] main_dat_q, main_dat_d;
  logic             accept;

  assign accept    = in_valid & in_ready;
  assign out_valid = main_vld_q;
  assign out_data  = main_dat_q;

`ifdef PIPE_STAGE_REG_SKID_EN
  logic             skid_vld_q, skid_vld_d;
  logic [WIDTH-1:0] skid_dat_q, skid_dat_d;

  // in_ready depends only on stored state; rst_n gating keeps it low during reset.
  assign in_ready = rst_n & ~skid_vld_q;

  always_comb begin
    main_vld_d = main_vld_q;
    main_dat_d = main_dat_q;
    skid_vld_d = skid_vld_q;
    skid_dat_d = skid_dat_q;
    if (flush) begin
      main_vld_d = 1'b0;
      skid_vld_d = 1'b0;
    end else if (skid_vld_q) begin
      if (out_ready) begin
        main_dat_d = skid_dat_q;
        main_vld_d = 1'b1;
        skid_vld_d = 1'b0;
      end
    end else if (accept) begin
      if (!main_vld_q || out_ready) begin
        main_dat_d = in_data;
        main_vld_d = 1'b1;
      end else begin
        skid_dat_d = in_data;
        skid_vld_d = 1'b1;
      end
    end else if (out_ready) begin
      main_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_vld_q <= 1'b0;
      skid_dat_q <= RESET_VAL;
    end else begin
      skid_vld_q <= skid_vld_d;
      skid_dat_q <= skid_dat_d;
    end
  end
`else
  logic issue;

  assign issue    = main_vld_q & out_ready;
  assign in_ready = rst_n & (~main_vld_q | out_ready);

  always_comb begin
    main_vld_d = main_vld_q;
    main_dat_d = main_dat_q;
    if (flush) begin
      main_vld_d = 1'b0;
    end else if (accept) begin
      main_dat_d = in_data;
      main_vld_d = 1'b1;
    end else if (issue) begin
      main_vld_d = 1'b0;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_vld_q <= 1'b0;
      main_dat_q <= RESET_VAL;
    end else begin
      main_vld_q <= main_vld_d;
      main_dat_q <= main_dat_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: queue-based reference model checked every
// cycle, plus literal expectations at key points of each scenario.
module tb_pipe_stage_reg;

  localparam int unsigned WIDTH = 8;
  localparam logic [WIDTH-1:0] RV = 8'hA5;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_data = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_data;

  int total = 0;
  int bad = 0;

  pipe_stage_reg #(.WIDTH(WIDTH), .RESET_VAL(RV)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an ordered queue of held payloads with a fixed capacity.
  logic [WIDTH-1:0] mq[$];
  logic [WIDTH-1:0] mhead = RV;
  bit m_acc, m_iss;

  function automatic bit model_rdy();
`ifdef PIPE_STAGE_REG_SKID_EN
    return rst_n && (mq.size() < 2);
`else
    return rst_n && (mq.size() == 0 || out_ready);
`endif
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      mhead = RV;
    end else begin
      m_acc = in_valid && model_rdy();
      m_iss = (mq.size() > 0) && out_ready;
      if (flush) begin
        mq.delete();
      end else begin
        if (m_iss) void'(mq.pop_front());
        if (m_acc) mq.push_back(in_data);
      end
      if (mq.size() > 0) mhead = mq[0];
    end
  end

  always @(negedge clk) begin
    check("m_out_valid", {31'd0, out_valid}, {31'd0, mq.size() > 0});
    check("m_out_data", {24'd0, out_data}, {24'd0, mhead});
    check("m_in_ready", {31'd0, in_ready}, {31'd0, model_rdy()});
  end

  // Apply inputs for the next edge, then return 1 time unit after that edge.
  task automatic step(input logic v, input logic [WIDTH-1:0] d, input logic r, input logic f);
    in_valid = v; in_data = d; out_ready = r; flush = f;
    @(posedge clk); #1;
  endtask

  initial begin
    // reset state
    @(posedge clk); @(posedge clk); #1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data", {24'd0, out_data}, 32'hA5);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    rst_n = 1'b1; #1;
    check("rst_rel_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;

    // streaming 1..8 with no gaps
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, 8'(i), 1'b1, 1'b0);
      check("stream_valid", {31'd0, out_valid}, 32'd1);
      check("stream_data", {24'd0, out_data}, 32'(i));
    end
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check("stream_drain", {31'd0, out_valid}, 32'd0);

`ifdef PIPE_STAGE_REG_SKID_EN
    // stall with skid: A, B, C, then B, C, D
    step(1'b1, 8'h0A, 1'b1, 1'b0);
    step(1'b1, 8'h0B, 1'b1, 1'b0);
    check("stall_b", {24'd0, out_data}, 32'h0B);
    step(1'b1, 8'h0C, 1'b0, 1'b0);
    check("stall_hold_b", {24'd0, out_data}, 32'h0B);
    check("stall_rdy_low", {31'd0, in_ready}, 32'd0);
    step(1'b1, 8'h0D, 1'b1, 1'b0);
    check("stall_c", {24'd0, out_data}, 32'h0C);
    check("stall_rdy_high", {31'd0, in_ready}, 32'd1);
    step(1'b1, 8'h0D, 1'b1, 1'b0);
    check("stall_d", {24'd0, out_data}, 32'h0D);
    step(1'b0, 8'h00, 1'b1, 1'b0);
`endif

    // stability under 5 cycles of back-pressure
    step(1'b1, 8'h10, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
      check("stable_data", {24'd0, out_data}, 32'h10);
      check("stable_valid", {31'd0, out_valid}, 32'd1);
    end
    step(1'b0, 8'h00, 1'b1, 1'b0);
`ifdef PIPE_STAGE_REG_SKID_EN
    check("stable_skid_out", {24'd0, out_data}, 32'h20);
    check("stable_skid_valid", {31'd0, out_valid}, 32'd1);
`else
    check("stable_empty", {31'd0, out_valid}, 32'd0);
`endif
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check("stable_no_extra", {31'd0, out_valid}, 32'd0);

    // flush with entries held and a pending input
    step(1'b1, 8'h31, 1'b0, 1'b0);
    step(1'b1, 8'h32, 1'b0, 1'b0);
    step(1'b1, 8'h55, 1'b0, 1'b1);
    check("flush_valid", {31'd0, out_valid}, 32'd0);
    check("flush_data_held", {24'd0, out_data}, 32'h31);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0);
      check("flush_stays_empty", {31'd0, out_valid}, 32'd0);
    end
    step(1'b1, 8'h56, 1'b1, 1'b1);
    check("flush_discards_acc", {31'd0, out_valid}, 32'd0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check("flush_no_56", {31'd0, out_valid}, 32'd0);

    // ready behaviour with main full, then simultaneous accept and issue
    step(1'b1, 8'h41, 1'b1, 1'b0);
    in_valid = 1'b1; in_data = 8'h42; out_ready = 1'b0; #1;
`ifdef PIPE_STAGE_REG_SKID_EN
    check("full_rdy_stall", {31'd0, in_ready}, 32'd1);
`else
    check("full_rdy_stall", {31'd0, in_ready}, 32'd0);
`endif
    out_ready = 1'b1; #1;
    check("full_rdy_go", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    check("acc_iss_data", {24'd0, out_data}, 32'h42);
    check("acc_iss_valid", {31'd0, out_valid}, 32'd1);
    step(1'b0, 8'h00, 1'b1, 1'b0);

    // asynchronous reset mid-stream with storage full
    step(1'b1, 8'h61, 1'b0, 1'b0);
    step(1'b1, 8'h62, 1'b0, 1'b0);
    rst_n = 1'b0; #1;
    check("amid_rst_valid", {31'd0, out_valid}, 32'd0);
    check("amid_rst_data", {24'd0, out_data}, 32'hA5);
    check("amid_rst_rdy", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1; #1;
    check("amid_rel_rdy", {31'd0, in_ready}, 32'd1);
    step(1'b1, 8'h63, 1'b1, 1'b0);
    check("amid_after_data", {24'd0, out_data}, 32'h63);

    // mixed traffic pattern, model-checked each cycle
    for (int i = 0; i < 40; i++)
      step((i % 3) != 2, 8'(8'h80 + i), (i % 4) != 1, i == 25);
    for (int i = 0; i < 4; i++)
      step(1'b0, 8'h00, 1'b1, 1'b0);
    check("final_empty", {31'd0, out_valid}, 32'd0);

    @(negedge clk); #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
